// File: rtl/eq2_bist_pkg.sv
// Shared definitions for the eq2 self-test engine: state encoding and vector width helper.
package eq2_bist_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int vec_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/eq2_bist_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Single-cycle update; no flow control, increments past full scale are dropped.
module sat_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/eq2_bist.sv
// Self-test engine for eq2: sweeps all {a,b} pairs, each held HOLD_CYCLES, samples aeqb on the last hold cycle.
// Run starts one cycle after start; optional first-error capture under EQ2_BIST_FIRST_ERR_EN.
module eq2_bist
  import eq2_bist_pkg::*;
#(
  parameter int W           = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      aeqb,
  output logic [W-1:0]              a,
  output logic [W-1:0]              b,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [vec_width(W)-1:0]   first_err_vec,
  output logic                      first_err_valid
);

  localparam int VW = vec_width(W);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q;
  logic [HW-1:0]   hold_q;
  logic            launch;
  logic            sample;
  logic            mismatch;

  assign a = vec_q[VW-1 -: W];
  assign b = vec_q[W-1:0];

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          sample = 1'b1;
          if (&vec_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mismatch = sample && (aeqb != (a == b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The vector freezes at all-ones on the final sample so a/b hold through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else if (launch) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else if (sample) begin
      hold_q <= '0;
      if (!(&vec_q)) vec_q <= vec_q + VW'(1);
    end else if (state_q == RUN) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  sat_counter #(.N(ERR_W)) u_err (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (launch),
    .inc     (mismatch),
    .count   (err_count)
  );

`ifdef EQ2_BIST_FIRST_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (launch) begin
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (mismatch && !first_err_valid) begin
      first_err_vec   <= vec_q;
      first_err_valid <= 1'b1;
    end
  end
`else
  assign first_err_vec   = '0;
  assign first_err_valid = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_eq2_bist.sv
// Directed bench for eq2_bist with a behavioural comparator model and an {a,b} scoreboard queue.
module tb_eq2_bist;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;   // 0 golden, 1 stuck-at-0, 2 stuck-at-1

  logic       aeqb;
  logic [1:0] a, b;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] first_err_vec;
  logic       first_err_valid;

  logic       aeqb2;
  logic [1:0] a2, b2;
  logic       busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [3:0] first_err_vec2;
  logic       first_err_valid2;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd1:    aeqb = 1'b0;
      2'd2:    aeqb = 1'b1;
      default: aeqb = (a == b);
    endcase
  end

  assign aeqb2 = (a2 != b2);

  eq2_bist #(.W(2), .HOLD_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .aeqb(aeqb),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  eq2_bist #(.W(2), .HOLD_CYCLES(4), .ERR_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .aeqb(aeqb2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_err_vec(first_err_vec2), .first_err_valid(first_err_valid2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_first(input string tag, input logic [3:0] vec, input logic vld,
                           input logic [3:0] e_vec, input logic e_vld);
`ifdef EQ2_BIST_FIRST_ERR_EN
    chk({tag, "_first_vec"}, 32'(vec), 32'(e_vec));
    chk({tag, "_first_valid"}, 32'(vld), 32'(e_vld));
`else
    chk({tag, "_first_vec"}, 32'(vec), 32'd0);
    chk({tag, "_first_valid"}, 32'(vld), 32'd0);
`endif
  endtask

  task automatic run(input string tag, input logic hold_start, input int e_err,
                     input logic e_pass, input logic [3:0] e_vec, input logic e_vld);
    @(negedge clk);
    start = 1'b1;
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 4; h++) exp_q.push_back(4'(v));
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk({tag, "_err_cleared"}, 32'(err_count), 32'd0);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s_ab%0d", tag, i), 32'({a, b}), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
    chk({tag, "_err_count"}, 32'(err_count), 32'(e_err));
    chk_first(tag, first_err_vec, first_err_valid, e_vec, e_vld);
  endtask

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ab", 32'({a, b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk_first("rst", first_err_vec, first_err_valid, 4'd0, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    mode = 2'd0;
    run("golden", 1'b0, 0, 1'b1, 4'd0, 1'b0);
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_busy", 32'(busy2), 32'd0);
    chk("sat_err", 32'(err_count2), 32'd3);
    chk("sat_pass", 32'(pass2), 32'd0);
    chk("sat_ab", 32'({a2, b2}), 32'hf);
    chk_first("sat", first_err_vec2, first_err_valid2, 4'b0000, 1'b1);

    mode = 2'd1;
    run("stuck0", 1'b0, 4, 1'b0, 4'b0000, 1'b1);
    chk("stuck0_ab_hold", 32'({a, b}), 32'hf);

    mode = 2'd2;
    run("stuck1_hold_start", 1'b1, 12, 1'b0, 4'b0001, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_holds", 32'(done), 32'd1);
    chk("done_err_holds", 32'(err_count), 32'd12);

    mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_err", 32'(err_count), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_ab", 32'({a, b}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_pass", 32'(pass), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk_first("arst", first_err_vec, first_err_valid, 4'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_ab", 32'({a, b}), 32'd0);

    mode = 2'd0;
    run("after_reset", 1'b0, 0, 1'b1, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
